// File: rtl/lcd_text_buffer.sv
// Double-buffered 32-char LCD text frame with cursor and serial clear.
// Define LCD_TEXT_BUFFER_AUTOCOMMIT_EN to mirror writes/clears into the display.
module lcd_text_buffer #(
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [7:0]   wr_char,
  input  logic         cmd_valid,
  input  logic [1:0]   cmd,
  input  logic [4:0]   cmd_pos,
  output logic         busy,
  output logic [4:0]   cursor,
  output logic         err_drop,
  output logic [127:0] line1,
  output logic [127:0] line2
);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  localparam logic [1:0] C_CLEAR  = 2'd0;
  localparam logic [1:0] C_HOME   = 2'd1;
  localparam logic [1:0] C_SETPOS = 2'd2;
  localparam logic [1:0] C_COMMIT = 2'd3;

  state_t     r_state;
  logic [7:0] r_w [32];
  logic [7:0] r_d [32];
  logic [4:0] r_cursor;
  logic [4:0] r_clr_idx;
  logic       r_err;

  logic [127:0] w_line1;
  logic [127:0] w_line2;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cursor  <= 5'd0;
      r_clr_idx <= 5'd0;
      r_err     <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        r_w[i] <= FILL_CHAR;
        r_d[i] <= FILL_CHAR;
      end
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            // a write colliding with a command loses
            r_err <= wr_en;
            unique case (cmd)
              C_CLEAR: begin
                r_state   <= S_CLEAR;
                r_clr_idx <= 5'd0;
              end
              C_HOME:   r_cursor <= 5'd0;
              C_SETPOS: r_cursor <= cmd_pos;
              C_COMMIT: r_d <= r_w;
            endcase
          end else if (wr_en) begin
            r_w[r_cursor] <= wr_char;
`ifdef LCD_TEXT_BUFFER_AUTOCOMMIT_EN
            r_d[r_cursor] <= wr_char;
`endif
            r_cursor <= r_cursor + 5'd1;
          end
        end
        S_CLEAR: begin
          r_err          <= wr_en | cmd_valid;
          r_w[r_clr_idx] <= FILL_CHAR;
          r_clr_idx      <= r_clr_idx + 5'd1;
          if (r_clr_idx == 5'd31) begin
            r_cursor <= 5'd0;
            r_state  <= S_IDLE;
`ifdef LCD_TEXT_BUFFER_AUTOCOMMIT_EN
            for (int i = 0; i < 32; i++) begin
              r_d[i] <= FILL_CHAR;
            end
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_line1 = '0;
    w_line2 = '0;
    for (int i = 0; i < 16; i++) begin
      w_line1[127-8*i -: 8] = r_d[i];
      w_line2[127-8*i -: 8] = r_d[16+i];
    end
  end

  assign busy     = (r_state == S_CLEAR);
  assign cursor   = r_cursor;
  assign err_drop = r_err;
  assign line1    = w_line1;
  assign line2    = w_line2;

endmodule
